// File: rtl/rm_tag_fifo.sv
// rm_tag_fifo: trigger-captured {LOCK, SNC, ENC} tag FIFO behind the CPLD-bridged VME strobe interface.
// Optional macro RM_TAG_TIMESTAMP_EN adds a 32-bit timestamp per entry, readable at address 4 after a pop.
module rm_tag_fifo #(
  parameter int ENC_W      = 14,
  parameter int SNC_W      = 10,
  parameter int DEPTH_LOG2 = 4,
  parameter int AFULL_TH   = 12,
  parameter int DROP_W     = 16
) (
  input  logic             SYSCLK,
  input  logic             RST_N,
  input  logic             TRIG,
  input  logic [ENC_W-1:0] ENC,
  input  logic [SNC_W-1:0] SNC,
  input  logic             LOCK,
  input  logic             FRS,
  input  logic             FWS,
  input  logic [4:0]       FA,
  input  logic [31:0]      DATA_IN,
  output logic [31:0]      DATA_OUT,
  output logic             DATA_OE,
  output logic             FDTACK,
  output logic             BUSY_OUT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_C  = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   AFULL_C  = AFULL_TH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [DROP_W-1:0]     DROP_ONE = 1;
  localparam logic [31:0]           BAD_ADDR = 32'hFEFE_FEFE;

  logic [1:0] trig_sreg, frs_sreg, fws_sreg;
  logic       trig_s, frs_s, fws_s;
  logic [1:0] trig_edge, frs_edge, fws_edge;
  logic       trig_arm, frs_arm, fws_arm;
  logic [2:0] warm;
  logic       trig_rise, frs_rise, fws_rise;

  // A strobe only arms once its synchronised level has been seen low after reset,
  // so a strobe held high across reset release cannot fake a rising edge.
  always_ff @(posedge SYSCLK) begin
    if (!RST_N) begin
      warm      <= '0;
      trig_sreg <= '0;
      frs_sreg  <= '0;
      fws_sreg  <= '0;
      trig_s    <= 1'b0;
      frs_s     <= 1'b0;
      fws_s     <= 1'b0;
      trig_edge <= '0;
      frs_edge  <= '0;
      fws_edge  <= '0;
      trig_arm  <= 1'b0;
      frs_arm   <= 1'b0;
      fws_arm   <= 1'b0;
    end else begin
      warm      <= {warm[1:0], 1'b1};
      trig_sreg <= {trig_sreg[0], TRIG};
      frs_sreg  <= {frs_sreg[0], FRS};
      fws_sreg  <= {fws_sreg[0], FWS};
      trig_s    <= trig_sreg[1];
      frs_s     <= frs_sreg[1];
      fws_s     <= fws_sreg[1];
      trig_edge <= {trig_edge[0], trig_s};
      frs_edge  <= {frs_edge[0], frs_s};
      fws_edge  <= {fws_edge[0], fws_s};
      trig_arm  <= trig_arm | (warm[2] & ~trig_s);
      frs_arm   <= frs_arm | (warm[2] & ~frs_s);
      fws_arm   <= fws_arm | (warm[2] & ~fws_s);
    end
  end

  assign trig_rise = trig_arm && (trig_edge == 2'b01);
  assign frs_rise  = frs_arm && (frs_edge == 2'b01);
  assign fws_rise  = fws_arm && (fws_edge == 2'b01);

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  ovf, busy_en;
  logic [DROP_W-1:0]     drop_cnt;
  logic                  flush, clr, pop, push_req, push_ok, drop;
  logic [31:0]           tag_word, status, rd_data;
  logic                  unused_data;

  assign unused_data = ^{DATA_IN[31:5], DATA_IN[3:2]};

  always_comb begin
    flush    = fws_rise && (FA == 5'd3) && DATA_IN[0];
    clr      = fws_rise && (FA == 5'd3) && DATA_IN[1];
    pop      = frs_rise && (FA == 5'd0) && (count != '0);
    push_req = trig_rise && !flush;
    push_ok  = push_req && ((count < DEPTH_C) || pop);
    drop     = push_req && !push_ok;
    tag_word     = 32'(ENC) | (32'(SNC) << ENC_W);
    tag_word[31] = LOCK;
    tag_word[30] = 1'b1;
  end

  always_ff @(posedge SYSCLK) begin
    if (push_ok) mem[wr_ptr] <= tag_word;
  end

  always_ff @(posedge SYSCLK) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
      busy_en  <= 1'b0;
      BUSY_OUT <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
        case ({push_ok, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
      if (clr) begin
        ovf      <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_ONE;
      end
      if (fws_rise && (FA == 5'd3)) busy_en <= DATA_IN[4];
      BUSY_OUT <= busy_en && (count >= AFULL_C);
    end
  end

`ifdef RM_TAG_TIMESTAMP_EN
  logic [31:0] ts_cnt, ts_head;
  logic [31:0] ts_mem [DEPTH];

  always_ff @(posedge SYSCLK) begin
    if (push_ok) ts_mem[wr_ptr] <= ts_cnt;
  end

  always_ff @(posedge SYSCLK) begin
    if (!RST_N) begin
      ts_cnt  <= '0;
      ts_head <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (pop) ts_head <= ts_mem[rd_ptr];
    end
  end
`endif

  always_comb begin
    status                 = '0;
    status[DEPTH_LOG2:0]   = count;
    status[16]             = (count == '0);
    status[17]             = (count == DEPTH_C);
    status[18]             = ovf;
    status[19]             = BUSY_OUT;
    case (FA)
      5'd0:    rd_data = (count != '0) ? mem[rd_ptr] : 32'd0;
      5'd1:    rd_data = status;
      5'd2:    rd_data = 32'(drop_cnt);
      5'd3:    rd_data = {27'd0, busy_en, 4'd0};
`ifdef RM_TAG_TIMESTAMP_EN
      5'd4:    rd_data = ts_head;
`endif
      default: rd_data = BAD_ADDR;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (!RST_N)        DATA_OUT <= '0;
    else if (frs_rise) DATA_OUT <= rd_data;
  end

  assign DATA_OE = frs_edge[0] & frs_arm;
  assign FDTACK  = ~(DATA_OE | (fws_s & fws_arm));

endmodule

// File: tb/tb_rm_tag_fifo.sv
// Self-checking bench for rm_tag_fifo: vector tables, aligned corner sequences and a randomized run
// against a queue-based reference model.
module tb_rm_tag_fifo;

  logic        SYSCLK = 1'b0;
  logic        RST_N  = 1'b0;
  logic        TRIG   = 1'b0;
  logic [13:0] ENC    = '0;
  logic [9:0]  SNC    = '0;
  logic        LOCK   = 1'b0;
  logic        FRS    = 1'b0;
  logic        FWS    = 1'b0;
  logic [4:0]  FA     = '0;
  logic [31:0] DATA_IN = '0;
  logic [31:0] DATA_OUT;
  logic        DATA_OE, FDTACK, BUSY_OUT;

  rm_tag_fifo dut (
    .SYSCLK(SYSCLK), .RST_N(RST_N), .TRIG(TRIG), .ENC(ENC), .SNC(SNC), .LOCK(LOCK),
    .FRS(FRS), .FWS(FWS), .FA(FA), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
    .DATA_OE(DATA_OE), .FDTACK(FDTACK), .BUSY_OUT(BUSY_OUT)
  );

  always #5 SYSCLK = ~SYSCLK;

  int checks = 0;
  int errors = 0;

  // Cycle count since reset, the same timebase the timestamp counter uses.
  logic [31:0] bcnt;
  always @(posedge SYSCLK) begin
    if (!RST_N) bcnt <= '0;
    else        bcnt <= bcnt + 32'd1;
  end

  // Reference model: tag queue plus flags, driven by the bench's own transactions.
  logic [31:0] mq[$];
  logic [31:0] mts[$];
  logic        m_ovf;
  logic [15:0] m_drop;
  logic        m_busy_en;
  logic [31:0] m_ts_reg;
  logic [31:0] last_ts;

  typedef struct { logic [4:0] addr; logic [31:0] exp; } rd_vec_t;
  typedef struct { logic [13:0] enc; logic [9:0] snc; logic lock; logic [31:0] exp; } tag_vec_t;

  function automatic logic [31:0] tagWord(input logic [13:0] enc, input logic [9:0] snc, input logic lock);
    return (32'(lock) << 31) | 32'h4000_0000 | (32'(snc) << 14) | 32'(enc);
  endfunction

  function automatic logic [31:0] mStatus();
    int n;
    n = mq.size();
    return 32'(n) | ((n == 0) ? 32'h1_0000 : 32'h0) | ((n == 16) ? 32'h2_0000 : 32'h0) |
           (m_ovf ? 32'h4_0000 : 32'h0) | ((m_busy_en && n >= 12) ? 32'h8_0000 : 32'h0);
  endfunction

  task automatic mReset();
    mq.delete();
    mts.delete();
    m_ovf = 1'b0;
    m_drop = '0;
    m_busy_en = 1'b0;
    m_ts_reg = '0;
  endtask

  task automatic mPush(input logic [31:0] word, input logic [31:0] ts);
    if (mq.size() < 16) begin
      mq.push_back(word);
      mts.push_back(ts);
    end else begin
      m_ovf = 1'b1;
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end
  endtask

  task automatic mRead(input logic [4:0] addr, output logic [31:0] exp);
    case (addr)
      5'd0: begin
        if (mq.size() == 0) exp = '0;
        else begin
          exp = mq.pop_front();
          m_ts_reg = mts.pop_front();
        end
      end
      5'd1: exp = mStatus();
      5'd2: exp = 32'(m_drop);
      5'd3: exp = m_busy_en ? 32'h10 : 32'h0;
`ifdef RM_TAG_TIMESTAMP_EN
      5'd4: exp = m_ts_reg;
`endif
      default: exp = 32'hFEFE_FEFE;
    endcase
  endtask

  task automatic mWrite(input logic [4:0] addr, input logic [31:0] d);
    if (addr == 5'd3) begin
      if (d[0]) begin
        mq.delete();
        mts.delete();
      end
      if (d[1]) begin
        m_ovf = 1'b0;
        m_drop = '0;
      end
      m_busy_en = d[4];
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic waitAck(input logic level, input string name);
    int n = 0;
    while (FDTACK !== level && n < 20) begin
      @(negedge SYSCLK);
      n++;
    end
    checkOutput(name, 32'(FDTACK), 32'(level));
  endtask

  task automatic applyStimulus(input logic [13:0] enc, input logic [9:0] snc, input logic lock);
    ENC = enc;
    SNC = snc;
    LOCK = lock;
    TRIG = 1'b1;
    @(negedge SYSCLK);
    last_ts = bcnt + 32'd3;
    @(negedge SYSCLK);
    TRIG = 1'b0;
    repeat (3) @(negedge SYSCLK);
    mPush(tagWord(enc, snc, lock), last_ts);
  endtask

  task automatic randomPush();
    applyStimulus(14'($urandom_range(0, 16383)), 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
  endtask

  task automatic vmeRead(input logic [4:0] addr, output logic [31:0] data);
    FA = addr;
    FRS = 1'b1;
    waitAck(1'b0, "read ack low");
    @(negedge SYSCLK);
    data = DATA_OUT;
    checkOutput("data_oe during read", 32'(DATA_OE), 32'd1);
    FRS = 1'b0;
    waitAck(1'b1, "read ack release");
    repeat (2) @(negedge SYSCLK);
  endtask

  task automatic vmeWrite(input logic [4:0] addr, input logic [31:0] data);
    FA = addr;
    DATA_IN = data;
    FWS = 1'b1;
    waitAck(1'b0, "write ack low");
    @(negedge SYSCLK);
    FWS = 1'b0;
    waitAck(1'b1, "write ack release");
    repeat (2) @(negedge SYSCLK);
    mWrite(addr, data);
  endtask

  task automatic readCheck(input logic [4:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] act;
    vmeRead(addr, act);
    checkOutput(name, act, exp);
  endtask

  task automatic readModel(input logic [4:0] addr, input string name);
    logic [31:0] act, exp;
    mRead(addr, exp);
    vmeRead(addr, act);
    checkOutput(name, act, exp);
  endtask

  task automatic doReset();
    RST_N = 1'b0;
    repeat (3) @(negedge SYSCLK);
    RST_N = 1'b1;
    mReset();
    repeat (6) @(negedge SYSCLK);
  endtask

  rd_vec_t  rvec[$];
  tag_vec_t tvec[$];

  initial begin
    logic [31:0] act, exp, ts;

    rvec.push_back('{5'd0,  32'h0000_0000});
    rvec.push_back('{5'd1,  32'h0001_0000});
    rvec.push_back('{5'd2,  32'h0000_0000});
    rvec.push_back('{5'd3,  32'h0000_0000});
    rvec.push_back('{5'd5,  32'hFEFE_FEFE});
    rvec.push_back('{5'd31, 32'hFEFE_FEFE});
`ifndef RM_TAG_TIMESTAMP_EN
    rvec.push_back('{5'd4,  32'hFEFE_FEFE});
`endif
    tvec.push_back('{14'h1234, 10'h2A5, 1'b1, 32'hC0A9_5234});
    tvec.push_back('{14'h0000, 10'h000, 1'b0, 32'h4000_0000});
    tvec.push_back('{14'h3FFF, 10'h3FF, 1'b0, 32'h40FF_FFFF});
    tvec.push_back('{14'h0001, 10'h001, 1'b1, 32'hC000_4001});

    @(negedge SYSCLK);
    doReset();
    checkOutput("reset BUSY_OUT", 32'(BUSY_OUT), 32'd0);
    checkOutput("reset FDTACK", 32'(FDTACK), 32'd1);
    checkOutput("reset DATA_OE", 32'(DATA_OE), 32'd0);
    checkOutput("reset DATA_OUT", DATA_OUT, 32'd0);
    foreach (rvec[i]) readCheck(rvec[i].addr, rvec[i].exp, $sformatf("reset read addr %0d", rvec[i].addr));

    // Tag packing table: push all, read back in order.
    foreach (tvec[i]) applyStimulus(tvec[i].enc, tvec[i].snc, tvec[i].lock);
    readModel(5'd1, "status after 4 pushes");
    foreach (tvec[i]) begin
      mRead(5'd0, exp);
      vmeRead(5'd0, act);
      checkOutput($sformatf("tag word %0d", i), act, tvec[i].exp);
    end
    readCheck(5'd1, 32'h0001_0000, "status empty after pops");

    // Almost-full busy threshold.
    vmeWrite(5'd3, 32'h10);
    readCheck(5'd3, 32'h10, "control busy_en");
    repeat (11) randomPush();
    repeat (2) @(negedge SYSCLK);
    checkOutput("busy at 11", 32'(BUSY_OUT), 32'd0);
    randomPush();
    repeat (2) @(negedge SYSCLK);
    checkOutput("busy at 12", 32'(BUSY_OUT), 32'd1);
    readModel(5'd1, "status with busy");
    readModel(5'd0, "pop at threshold");
    checkOutput("busy after pop", 32'(BUSY_OUT), 32'd0);
    vmeWrite(5'd3, 32'h1);
    readCheck(5'd1, 32'h0001_0000, "status after flush");

    // Overflow and drop counting.
    repeat (18) randomPush();
    readCheck(5'd1, 32'h0006_0010, "status full ovf");
    readCheck(5'd2, 32'd2, "drop count 2");
    vmeWrite(5'd3, 32'h2);
    readCheck(5'd1, 32'h0002_0010, "status ovf cleared");
    readCheck(5'd2, 32'd0, "drop cleared");

    // Push aligned with a head pop while full.
    ENC = 14'h0ABC; SNC = 10'h155; LOCK = 1'b0;
    TRIG = 1'b1; FA = 5'd0; FRS = 1'b1;
    repeat (2) @(negedge SYSCLK);
    TRIG = 1'b0;
    repeat (3) @(negedge SYSCLK);
    act = DATA_OUT;
    mRead(5'd0, exp);
    mPush(tagWord(14'h0ABC, 10'h155, 1'b0), 32'd0);
    checkOutput("aligned pop oldest", act, exp);
    FRS = 1'b0;
    waitAck(1'b1, "aligned ack release");
    repeat (2) @(negedge SYSCLK);
    readCheck(5'd1, 32'h0002_0010, "status after aligned push/pop");
    for (int i = 0; i < 16; i++) readModel(5'd0, $sformatf("ordered pop %0d", i));
    readCheck(5'd0, 32'd0, "empty pop");
    readModel(5'd1, "status drained");

    // Flush in the same cycle as a push: push discarded, no drop.
    repeat (3) randomPush();
    FA = 5'd3; DATA_IN = 32'h1; FWS = 1'b1; TRIG = 1'b1;
    repeat (2) @(negedge SYSCLK);
    TRIG = 1'b0;
    repeat (3) @(negedge SYSCLK);
    FWS = 1'b0;
    waitAck(1'b1, "flush ack release");
    repeat (2) @(negedge SYSCLK);
    mWrite(5'd3, 32'h1);
    readCheck(5'd1, 32'h0001_0000, "status flush vs push");
    readCheck(5'd2, 32'd0, "no drop on flush");

`ifdef RM_TAG_TIMESTAMP_EN
    applyStimulus(14'h0042, 10'h011, 1'b1);
    ts = last_ts;
    readModel(5'd0, "ts pop");
    readCheck(5'd4, ts, "timestamp of pop");
    readModel(5'd0, "ts empty pop");
    readCheck(5'd4, ts, "timestamp kept on empty read");
`endif

    // Randomized traffic against the model.
    for (int it = 0; it < 80; it++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r <= 4) randomPush();
      else if (r <= 7) readModel(5'd0, "rand pop");
      else if (r == 8) readModel(5'd1, "rand status");
      else if (r == 9) readModel(5'd2, "rand drop");
      else if (r == 10) vmeWrite(5'd3, ($urandom_range(0, 3) == 0) ? 32'h1 : ($urandom & 32'h12));
      else readModel(($urandom_range(0, 1) == 0) ? 5'd3 : 5'($urandom_range(5, 31)), "rand other addr");
    end

    // Reset during a read; held strobe must not re-trigger.
    FA = 5'd1;
    FRS = 1'b1;
    waitAck(1'b0, "pre-reset ack");
    RST_N = 1'b0;
    @(negedge SYSCLK);
    checkOutput("midread reset DATA_OE", 32'(DATA_OE), 32'd0);
    checkOutput("midread reset FDTACK", 32'(FDTACK), 32'd1);
    checkOutput("midread reset BUSY_OUT", 32'(BUSY_OUT), 32'd0);
    checkOutput("midread reset DATA_OUT", DATA_OUT, 32'd0);
    RST_N = 1'b1;
    mReset();
    repeat (10) @(negedge SYSCLK);
    checkOutput("held strobe no ack", 32'(FDTACK), 32'd1);
    checkOutput("held strobe no oe", 32'(DATA_OE), 32'd0);
    FRS = 1'b0;
    repeat (6) @(negedge SYSCLK);
    readCheck(5'd1, 32'h0001_0000, "status after midread reset");
    readCheck(5'd0, 32'd0, "head after midread reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rm_tag_fifo.md
Name: rm_tag_fifo

Overview:
- Parametrised successor to the GPIO-RM single-register event/spill tag latch.
- Captures {LOCK, SNC, ENC} on every TRIG rising edge into a DEPTH-entry FIFO, so the host can read tags back without losing events between VME reads.
- Provides status, a saturating drop counter, a control register and a programmable almost-full BUSY contribution toward the MTM.
- Sits between RM inputs and the CPLD-bridged VME strobe interface (FRS/FWS/FA/FDTACK).

Parameters:
- ENC_W, 14, event-number width captured; ENC_W+SNC_W <= 30.
- SNC_W, 10, spill-number width captured.
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries; range 1..8.
- AFULL_TH, 12, occupancy at or above which BUSY_OUT asserts (when enabled); 1..DEPTH.
- DROP_W, 16, drop counter width; saturates.

Ports:
- SYSCLK, in, 1, 32 MHz system clock; the single clock.
- RST_N, in, 1, synchronous active-low reset, sampled on SYSCLK rising edge.
- TRIG, in, 1, asynchronous trigger (TRIG2 from the RM).
- ENC, in, ENC_W, event number counter; stable around TRIG.
- SNC, in, SNC_W, spill number counter.
- LOCK, in, 1, RM lock status.
- FRS, in, 1, asynchronous read strobe from the CPLD.
- FWS, in, 1, asynchronous write strobe from the CPLD.
- FA, in, 5, register address.
- DATA_IN, in, 32, VME write data.
- DATA_OUT, out, 32, VME read data.
- DATA_OE, out, 1, tristate enable for the DATA bus.
- FDTACK, out, 1, data acknowledge to the CPLD, active-low.
- BUSY_OUT, out, 1, almost-full busy, active-high, registered.

Behaviour:
- Synchronisers:
  - TRIG, FRS and FWS each pass through a 3-flop synchroniser (2 sreg flops plus an output flop).
  - A 2-bit edge register follows each synchroniser; a "rise" is edge==2'b01.
- Push:
  - On a TRIG rise, ENC, SNC and LOCK are sampled in the rise cycle.
  - Entry word: [31]=LOCK, [30]=1 (valid), [ENC_W+SNC_W-1:ENC_W]=SNC, [ENC_W-1:0]=ENC, remaining bits 0.
  - Latency: 5 SYSCLK edges from the first edge that samples TRIG high until the count increments.
- Full:
  - A push is accepted if count < DEPTH, or if a pop happens in the same cycle.
  - Otherwise the entry is dropped: OVF sticky is set and the drop counter increments, saturating at all-ones.
- Simultaneous push and pop: both are performed; count is unchanged; read data is the old head.
- Read:
  - On an FRS rise, DATA_OUT is loaded from the register selected by FA.
  - DATA_OE and FDTACK=0 follow the synchronised FRS level, delayed by one edge-register stage; both deassert likewise.
- Write: on an FWS rise, the addressed register is written. FDTACK=0 while synchronised FWS is high.
- Register map:
  - 0, R: FIFO head; the read pops it. If empty, returns 0 (valid bit 0) and does not pop.
  - 1, R: status. [DEPTH_LOG2:0]=count, [16]=empty, [17]=full, [18]=OVF, [19]=BUSY_OUT.
  - 2, R: drop counter, zero-extended.
  - 3, R/W: control. [0] flush (write-1, self-clearing, reads 0), [1] clear OVF and drop counter (write-1, self-clearing), [4] busy_en (persistent).
  - Other addresses: read returns 32'hFEFEFEFE; writes are ignored.
- Flush vs push: a flush takes effect in the write cycle and empties the FIFO. A push in the same cycle is discarded without counting as a drop.
- Pointers: DEPTH_LOG2-bit read/write pointers wrap modulo DEPTH. count is DEPTH_LOG2+1 bits.
- BUSY_OUT: registered; high when busy_en=1 and count >= AFULL_TH.
- Reset (RST_N=0 at an edge), including mid-transfer:
  - FIFO empty, pointers 0, OVF 0, drop 0, control 0.
  - DATA_OUT=0, DATA_OE=0, FDTACK=1, BUSY_OUT=0.
  - All synchroniser and edge flops cleared; a strobe held across reset release produces no rise until it goes low then high again.

Optional Feature:
- Macro: RM_TAG_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running counter (reset 0, wraps) is stored alongside each entry.
  - A pop of address 0 latches that entry's timestamp into register 4 (R).
  - An empty read leaves register 4 unchanged.
- Undefined: no counter and no extra storage; address 4 reads 32'hFEFEFEFE.

Test Plan:
- Reset, then read addresses 0..3 -> 0x00000000, 0x00010000, 0x00000000, 0x00000000; FDTACK pulses low per access; BUSY_OUT=0.
- ENC=0x1234, SNC=0x2A5, LOCK=1, one TRIG pulse; read address 0 -> 0xC0A95234; then status count=0, empty=1.
- Write control=0x10 (busy_en); 12 TRIG pulses -> BUSY_OUT=1 after the 12th push; one pop -> BUSY_OUT=0.
- 18 TRIG pulses with DEPTH=16 -> status full=1, OVF=1; drop register=2; 16 pops return tags in order; write control=0x2 -> OVF=0, drop=0.
- Align a TRIG rise with an address-0 pop while full -> count stays 16; the popped word is the oldest entry; OVF stays 0.
- With RM_TAG_TIMESTAMP_EN defined: push at timestamp T, pop -> address 4 = T. Assert RST_N=0 mid-read -> DATA_OE=0 and FDTACK=1 on the next edge.
